flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_pkg.sv | 29 ++
 rtl/flag_stack.sv | 89 ++++++++
 rtl/flag_unit.sv | 130 +++++++++++++
 tb/tb_flag_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// flag_pkg: shared definitions for the flag unit.
//   - flags_t      : 4-bit flag vector {S,Z,C,V}
//   - FLAG_*       : bit positions of each flag inside flags_t
//   - COND_*       : encodings of the 4-bit condition select (IR cond field)
package flag_pkg;

  typedef logic [3:0] flags_t;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_NEVER  = 4'b0000;
  localparam logic [3:0] COND_ALWAYS = 4'b0001;
  localparam logic [3:0] COND_CS     = 4'b0010; // C
  localparam logic [3:0] COND_CC     = 4'b0011; // ~C
  localparam logic [3:0] COND_EQ     = 4'b0100; // Z
  localparam logic [3:0] COND_NE     = 4'b0101; // ~Z
  localparam logic [3:0] COND_VS     = 4'b0110; // V
  localparam logic [3:0] COND_VC     = 4'b0111; // ~V
  localparam logic [3:0] COND_MI     = 4'b1000; // S
  localparam logic [3:0] COND_PL     = 4'b1001; // ~S
  localparam logic [3:0] COND_LT     = 4'b1010; // S^V, signed less-than
  localparam logic [3:0] COND_GE     = 4'b1011; // ~(S^V)
  localparam logic [3:0] COND_HI     = 4'b1100; // C&~Z, unsigned higher
  localparam logic [3:0] COND_LS     = 4'b1101; // ~C|Z

endpackage

// File: rtl/flag_stack.sv
// flag_stack: LIFO for saved flag vectors.
//   clk, reset : clock, asynchronous active-high reset (clears sp and entries)
//   push, pop  : save / restore requests; both together is a no-op
//   din        : flags to save on push
//   dout       : entry at the top of the stack (stack[sp-1]), combinational
//   full/empty : occupancy status
//   sp         : current occupancy, 0..DEPTH
// Requests that would overflow or underflow are ignored here; error
// reporting is left to the instantiating block.
module flag_stack
  import flag_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  flags_t         din,
  output flags_t         dout,
  output logic           full,
  output logic           empty,
  output logic [SPW-1:0] sp
);

  logic [SPW-1:0] sp_q, sp_d;
  flags_t         stack_q [DEPTH];
  flags_t         stack_d [DEPTH];
  logic           push_ok;
  logic           pop_ok;

  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign sp      = sp_q;

  always_comb begin
    sp_d = sp_q;
    if (push_ok) begin
      sp_d = sp_q + 1'b1;
    end else if (pop_ok) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // One register per entry; entry gi is written only when it is the next
  // free slot.  Entries are flops (not RAM) so they can clear on reset.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
        stack_d[gi] = stack_q[gi];
        if (push_ok && (sp_q == SPW'(gi))) begin
          stack_d[gi] = din;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stack_q[gi] <= '0;
        end else begin
          stack_q[gi] <= stack_d[gi];
        end
      end
    end
  endgenerate

  // Top-of-stack read as a compare-based mux, so sp never has to be used
  // directly as an array index of a mismatched width.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) begin
        dout = stack_q[i];
      end
    end
  end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: add/subtract flag generation, flag register, condition decode
// and a flag save/restore stack.
//   clk, reset  : clock, asynchronous active-high reset
//   a_in, b_in  : WIDTH-bit operands
//   sub_in      : 0 = add, 1 = subtract (a_in - b_in)
//   ld_flag     : load computed flags into the flag register
//   cond        : condition select, see COND_* in flag_pkg
//   push, pop   : save / restore the flag register on the stack
//   flags       : registered {S,Z,C,V}
//   cc          : condition result from registered flags
//   sp          : stack occupancy
//   stk_err     : sticky overflow/underflow indication
module flag_unit
  import flag_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             a_in,
  input  logic [WIDTH-1:0]             b_in,
  input  logic                         sub_in,
  input  logic                         ld_flag,
  input  logic [3:0]                   cond,
  input  logic                         push,
  input  logic                         pop,
  output logic [3:0]                   flags,
  output logic                         cc,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stk_err
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry_into_msb;
  flags_t           new_flags;
  flags_t           flags_q, flags_d;
  logic             stk_err_q, stk_err_d;
  flags_t           stk_top;
  logic             stk_full;
  logic             stk_empty;
  logic             pop_taken;
  logic             err_set;

  // Subtract is a + ~b + 1, so C=1 after a subtract means "no borrow".
  assign b_eff = sub_in ? ~b_in : b_in;
  assign sum   = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_in};

  // The sum bit at the MSB is a^b^cin, so the carry into the MSB falls out
  // of the operand and result MSBs.
  assign carry_into_msb = a_in[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];

  always_comb begin
    new_flags         = '0;
    new_flags[FLAG_S] = sum[WIDTH-1];
    new_flags[FLAG_Z] = (sum[WIDTH-1:0] == '0);
    new_flags[FLAG_C] = sum[WIDTH];
    new_flags[FLAG_V] = carry_into_msb ^ sum[WIDTH];
  end

  flag_stack #(
    .DEPTH (DEPTH),
    .SPW   (SPW)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (flags_q),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .sp    (sp)
  );

  // push+pop together cancels: no stack change and no error.
  assign pop_taken = pop & ~push & ~stk_empty;
  assign err_set   = (push & ~pop & stk_full) | (pop & ~push & stk_empty);

  // A successful pop has priority over ld_flag; a push saves flags_q, i.e.
  // the value before any same-cycle load.
  always_comb begin
    flags_d = flags_q;
    if (pop_taken) begin
      flags_d = stk_top;
    end else if (ld_flag) begin
      flags_d = new_flags;
    end
  end

  assign stk_err_d = stk_err_q | err_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      stk_err_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign flags   = flags_q;
  assign stk_err = stk_err_q;

  always_comb begin
    cc = 1'b0;
    case (cond)
      COND_NEVER:  cc = 1'b0;
      COND_ALWAYS: cc = 1'b1;
      COND_CS:     cc = flags_q[FLAG_C];
      COND_CC:     cc = ~flags_q[FLAG_C];
      COND_EQ:     cc = flags_q[FLAG_Z];
      COND_NE:     cc = ~flags_q[FLAG_Z];
      COND_VS:     cc = flags_q[FLAG_V];
      COND_VC:     cc = ~flags_q[FLAG_V];
      COND_MI:     cc = flags_q[FLAG_S];
      COND_PL:     cc = ~flags_q[FLAG_S];
      COND_LT:     cc = flags_q[FLAG_S] ^ flags_q[FLAG_V];
      COND_GE:     cc = ~(flags_q[FLAG_S] ^ flags_q[FLAG_V]);
      COND_HI:     cc = flags_q[FLAG_C] & ~flags_q[FLAG_Z];
      COND_LS:     cc = ~flags_q[FLAG_C] | flags_q[FLAG_Z];
      default:     cc = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed scenarios plus randomized traffic, checked against
// an arithmetic/queue reference model of the flag unit.
module tb_flag_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sub_in;
  logic             ld_flag;
  logic [3:0]       cond;
  logic             push;
  logic             pop;
  logic [3:0]       flags;
  logic             cc;
  logic [SPW-1:0]   sp;
  logic             stk_err;

  always #5 clk = ~clk;

  flag_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .a_in    (a_in),
    .b_in    (b_in),
    .sub_in  (sub_in),
    .ld_flag (ld_flag),
    .cond    (cond),
    .push    (push),
    .pop     (pop),
    .flags   (flags),
    .cc      (cc),
    .sp      (sp),
    .stk_err (stk_err)
  );

  // Reference model state
  logic [3:0] m_flags;
  logic [3:0] m_stack[$];
  logic       m_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flags from plain integer arithmetic: unsigned result for C, signed
  // result range for V.
  function automatic logic [3:0] alu_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic sub);
    longint mod  = longint'(1) << WIDTH;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint sa   = a[WIDTH-1] ? ua - mod : ua;
    longint sb   = b[WIDTH-1] ? ub - mod : ub;
    longint ures;
    longint sres;
    longint r;
    logic   c;
    logic   v;
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      c    = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      c    = (ures >= mod);
    end
    r = ((ures % mod) + mod) % mod;
    v = (sres > (mod / 2) - 1) || (sres < -(mod / 2));
    return {(r >= mod / 2), (r == 0), c, v};
  endfunction

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic s = f[3];
    logic z = f[2];
    logic cy = f[1];
    logic v = f[0];
    case (c)
      4'd0:  return 1'b0;
      4'd1:  return 1'b1;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return z;
      4'd5:  return !z;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return s;
      4'd9:  return !s;
      4'd10: return s != v;
      4'd11: return s == v;
      4'd12: return cy && !z;
      4'd13: return !cy || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    a_in    = '0;
    b_in    = '0;
    sub_in  = 1'b0;
    ld_flag = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
  endtask

  // One clocked transaction: check cc before the edge, update the model at
  // the edge, check registered state just after it.
  task automatic cycle(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       input logic ld, input logic [3:0] c, input logic pu, input logic po);
    logic [3:0] nf;
    a_in = a; b_in = b; sub_in = s; ld_flag = ld; cond = c; push = pu; pop = po;
    #1;
    check("cc", {31'b0, cc}, {31'b0, cond_model(c, m_flags)});
    nf = alu_flags(a, b, s);
    @(posedge clk);
    if (pu && po) begin
      if (ld) m_flags = nf;
    end else if (pu) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
      else m_err = 1'b1;
      if (ld) m_flags = nf;
    end else if (po) begin
      if (m_stack.size() > 0) m_flags = m_stack.pop_back();
      else begin
        m_err = 1'b1;
        if (ld) m_flags = nf;
      end
    end else if (ld) begin
      m_flags = nf;
    end
    #1;
    check("flags", {28'b0, flags}, {28'b0, m_flags});
    check("sp", 32'(sp), 32'(m_stack.size()));
    check("stk_err", {31'b0, stk_err}, {31'b0, m_err});
    n_txn++;
    $display("txn %0d a=%h b=%h sub=%b ld=%b cond=%h push=%b pop=%b -> flags=%b sp=%0d err=%b",
             n_txn, a, b, s, ld, c, pu, po, flags, sp, stk_err);
    idle_inputs();
  endtask

  // Apply cond with no clock activity and compare cc against a constant.
  task automatic cond_check(input string tag, input logic [3:0] c, input logic exp);
    cond = c;
    #1;
    check(tag, {31'b0, cc}, {31'b0, exp});
  endtask

  // Asynchronous reset raised between edges; state must clear immediately.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    #1;
    check("rst_flags", {28'b0, flags}, 32'd0);
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_err", {31'b0, stk_err}, 32'd0);
    m_flags = '0;
    m_stack.delete();
    m_err   = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    $display("txn reset");
  endtask

  initial begin
    logic [WIDTH-1:0] corners [6];
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    corners[0] = 16'h0000; corners[1] = 16'h0001; corners[2] = 16'h7FFF;
    corners[3] = 16'h8000; corners[4] = 16'hFFFF; corners[5] = 16'h0005;
    cond = 4'd0;
    do_reset();

    // Signed overflow on add
    cycle(16'h7FFF, 16'h0001, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    check("ovf_flags", {28'b0, flags}, 32'b1001);
    cond_check("ovf_vs", 4'b0110, 1'b1);
    cond_check("ovf_lt", 4'b1010, 1'b0);

    // Equal subtract
    cycle(16'h0005, 16'h0005, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    check("eq_flags", {28'b0, flags}, 32'b0110);
    cond_check("eq_eq", 4'b0100, 1'b1);
    cond_check("eq_hi", 4'b1100, 1'b0);
    cond_check("eq_res", 4'b1111, 1'b0);

    // Carry wrap, then borrow
    cycle(16'hFFFF, 16'h0001, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    check("wrap_flags", {28'b0, flags}, 32'b0110);
    cycle(16'h0000, 16'h0001, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    check("borrow_flags", {28'b0, flags}, 32'b1000);
    cond_check("borrow_ls", 4'b1101, 1'b1);

    // Fill the stack with distinct flags, overflow, then drain in LIFO order
    cycle(16'h7FFF, 16'h0001, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0); // 1001
    cycle(16'h0005, 16'h0005, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0); // push 1001
    cycle(16'h0000, 16'h0001, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0); // push 0110
    cycle(16'h0001, 16'h0001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // push 1000
    cycle(16'h8000, 16'h8000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0); // push 0000
    check("fill_sp", 32'(sp), 32'd4);
    check("fill_flags", {28'b0, flags}, 32'b0111);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("ovf_sp", 32'(sp), 32'd4);
    check("ovf_err", {31'b0, stk_err}, 32'd1);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("pop1", {28'b0, flags}, 32'b0000);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("pop2", {28'b0, flags}, 32'b1000);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("pop3", {28'b0, flags}, 32'b0110);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("pop4", {28'b0, flags}, 32'b1001);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("under_flags", {28'b0, flags}, 32'b1001);
    check("under_sp", 32'(sp), 32'd0);

    // push with simultaneous load, then push+pop cancel
    do_reset();
    cycle(16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0); // 0100
    cycle(16'h7FFF, 16'h0001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("pushld_flags", {28'b0, flags}, 32'b1001);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    check("pp_sp", 32'(sp), 32'd1);
    check("pp_err", {31'b0, stk_err}, 32'd0);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    check("pushld_top", {28'b0, flags}, 32'b0100);

    // Underflow error, three pushes, then async reset between edges
    cycle(16'h0001, 16'h0001, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1); // underflow, ld applies
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("pre_rst_sp", 32'(sp), 32'd3);
    check("pre_rst_err", {31'b0, stk_err}, 32'd1);
    push = 1'b1; // pending push abandoned by reset
    #2;
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : WIDTH'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : WIDTH'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        push    = 1'($urandom);
        pop     = 1'($urandom);
        ld_flag = 1'b1;
        a_in    = ra;
        #2;
        do_reset();
      end else begin
        cycle(ra, rb, 1'($urandom), ($urandom_range(0, 1) == 1), 4'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
